// File: rtl/friscv_rv32i_control.sv
// RV32I control unit: fetches one instruction at a time, executes jumps, branches,
// AUIPC and FENCE locally, and hands everything else to the processing unit.
//
// state | meaning
// BOOT  | one idle cycle after reset before the first fetch
// FETCH | fetch request on inst_addr, waiting for inst_rdy
// EXEC  | captured instruction is resolved or dispatched
// TRAP  | illegal opcode or misaligned target; parked until srst
module friscv_rv32i_control #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic            aclk,
  input  logic            srst,
  output logic            inst_en,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_rdy,
  input  logic [XLEN-1:0] inst_rdata,
  output logic            proc_en,
  input  logic            proc_ready,
  output logic [XLEN-1:0] proc_instruction,
  output logic [4:0]      ctrl_rs1_addr,
  output logic [4:0]      ctrl_rs2_addr,
  input  logic [XLEN-1:0] ctrl_rs1_val,
  input  logic [XLEN-1:0] ctrl_rs2_val,
  output logic            ctrl_rd_wr,
  output logic [4:0]      ctrl_rd_addr,
  output logic [XLEN-1:0] ctrl_rd_val,
  output logic            inst_err,
  output logic [XLEN-1:0] pc
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            err_q, err_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] pc_plus4, jal_tgt, jalr_sum, jalr_tgt, br_tgt;
  logic            is_dispatch, writes_rd;
  logic            br_f3_ok, br_taken;

  // ---------------------------------------------------------------- decode
  assign opcode = instr_q[6:0];
  assign rd     = instr_q[11:7];
  assign funct3 = instr_q[14:12];

  assign imm_i = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
  assign imm_b = {{(XLEN-12){instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j = {{(XLEN-20){instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_u = {{(XLEN-31){instr_q[31]}}, instr_q[30:12], 12'b0};

  assign pc_plus4 = pc_q + FOUR;
  assign jal_tgt  = pc_q + imm_j;
  assign jalr_sum = ctrl_rs1_val + imm_i;
  assign jalr_tgt = {jalr_sum[XLEN-1:1], 1'b0};
  assign br_tgt   = pc_q + imm_b;

  assign is_dispatch = (opcode == OPC_LUI)   || (opcode == OPC_LOAD) ||
                       (opcode == OPC_STORE) || (opcode == OPC_OPIMM) ||
                       (opcode == OPC_OP)    || (opcode == OPC_SYSTEM);
  assign writes_rd   = (opcode == OPC_JAL) || (opcode == OPC_JALR) || (opcode == OPC_AUIPC);

  assign br_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (ctrl_rs1_val == ctrl_rs2_val);
      3'b001:  br_taken = (ctrl_rs1_val != ctrl_rs2_val);
      3'b100:  br_taken = ($signed(ctrl_rs1_val) <  $signed(ctrl_rs2_val));
      3'b101:  br_taken = ($signed(ctrl_rs1_val) >= $signed(ctrl_rs2_val));
      3'b110:  br_taken = (ctrl_rs1_val <  ctrl_rs2_val);
      3'b111:  br_taken = (ctrl_rs1_val >= ctrl_rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- state register
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= BOOT;
      pc_q    <= BOOT_ADDR;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (inst_rdy) begin
          instr_d = inst_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Any fault leaves pc on the faulting instruction.
        if (is_dispatch) begin
          if (proc_ready) begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end else begin
          case (opcode)
            OPC_JAL: begin
              if (jal_tgt[1:0] != 2'b00) begin
                state_d = TRAP;
                err_d   = 1'b1;
              end else begin
                pc_d    = jal_tgt;
                state_d = FETCH;
              end
            end
            OPC_JALR: begin
              if (jalr_tgt[1:0] != 2'b00) begin
                state_d = TRAP;
                err_d   = 1'b1;
              end else begin
                pc_d    = jalr_tgt;
                state_d = FETCH;
              end
            end
            OPC_AUIPC, OPC_FENCE: begin
              pc_d    = pc_plus4;
              state_d = FETCH;
            end
            OPC_BRANCH: begin
              if (!br_f3_ok || (br_taken && (br_tgt[1:0] != 2'b00))) begin
                state_d = TRAP;
                err_d   = 1'b1;
              end else begin
                pc_d    = br_taken ? br_tgt : pc_plus4;
                state_d = FETCH;
              end
            end
            default: begin
              state_d = TRAP;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      TRAP: state_d = TRAP;
      default: state_d = BOOT;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    inst_en          = (state_q == FETCH);
    inst_addr        = pc_q;
    pc               = pc_q;
    proc_en          = (state_q == EXEC) && is_dispatch;
    proc_instruction = instr_q;
    ctrl_rs1_addr    = instr_q[19:15];
    ctrl_rs2_addr    = instr_q[24:20];
    ctrl_rd_addr     = rd;
    ctrl_rd_val      = (opcode == OPC_AUIPC) ? (pc_q + imm_u) : pc_plus4;
    ctrl_rd_wr       = (state_q == EXEC) && writes_rd && (rd != 5'd0) && (state_d != TRAP);
    inst_err         = err_q;
  end

endmodule
